// File: rtl/noc_pkg.sv
// Shared NoC definitions: address, header and flit formats plus the flit type
// enum. Every NoC block imports these rather than defining its own copy.
package noc_pkg;

    localparam int PAYLOAD_W = 32;
    localparam int COORD_W   = 4;
    localparam int HDR_W     = 4 * COORD_W;

    typedef enum logic [1:0] {
        HEADER = 2'd0,
        BODY   = 2'd1,
        TAIL   = 2'd2
    } flit_type_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } addr_t;

    typedef struct packed {
        addr_t dst_addr;
        addr_t src_addr;
    } flit_hdr_t;

    typedef struct packed {
        flit_type_e             flit_type;
        logic [PAYLOAD_W-1:0]   payload;
    } flit_t;

    // The flit driven whenever nothing valid is on the link. BODY is used
    // because the router samples flit_type even while enable is low.
    localparam flit_t IDLE_FLIT = '{flit_type: BODY, payload: '0};

    // A header occupies the low bits of the payload; the rest is zero.
    function automatic logic [PAYLOAD_W-1:0] hdr_to_payload(input flit_hdr_t hdr);
        return {{(PAYLOAD_W - HDR_W){1'b0}}, hdr};
    endfunction

endpackage

// File: rtl/node_port.sv
// Link between a node-side injector and the router's local input port.
// Handshake: the sender raises enable with a flit and holds both stable
// until the rising edge where enable && ack; that edge transfers the flit.
interface node_port;
    import noc_pkg::*;

    flit_t flit;
    logic  enable;
    logic  ack;

    modport up   (output flit, output enable, input ack);
    modport down (input flit, input enable, output ack);

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc_i and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: step by one unless already at the ceiling.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/packet_injector.sv
// Packet injector: turns a request (destination, length) plus a stream of
// payload words into HEADER / BODY... / TAIL flits on the router's local
// input port. Optional statistics counters are built only when the macro
// PACKET_INJECTOR_STATS_EN is defined.
//
// Handshakes: req and data are valid/ready (transfer on valid && ready);
// the flit link transfers on enable && ack and never retracts a flit.
module packet_injector
    import noc_pkg::*;
#(
    parameter int X       = 1,
    parameter int Y       = 1,
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  addr_t                req_dst,
    input  logic [LEN_W-1:0]     req_len,
    input  logic                 data_valid,
    output logic                 data_ready,
    input  logic [PAYLOAD_W-1:0] data,
    output logic [1:0]           dbg_state_o,
`ifdef PACKET_INJECTOR_STATS_EN
    output logic [15:0]          pkt_count,
    output logic [15:0]          stall_count,
`endif
    node_port.up                 port_up
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_BODY = 2'd2
    } state_e;

    state_e           state_q, state_d;
    flit_t            flit_q, flit_d;
    logic             enable_q, enable_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;

    logic             xfer;
    logic             req_hs;
    logic             data_hs;
    logic [LEN_W-1:0] len_clamped;
    flit_hdr_t        hdr;
    flit_t            word_flit;

    // ack only counts while a flit is actually offered.
    assign xfer    = enable_q && port_up.ack;
    assign req_hs  = req_valid && req_ready;
    assign data_hs = data_valid && data_ready;

    // Oversized requests are cut to MAX_LEN so the down-counter cannot wrap.
    assign len_clamped = (req_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : req_len;

    assign hdr = '{dst_addr: req_dst,
                   src_addr: '{x: COORD_W'(X), y: COORD_W'(Y)}};

    // The last remaining word becomes the TAIL.
    assign word_flit = '{flit_type: (cnt_q == LEN_W'(1)) ? TAIL : BODY,
                         payload:   data};

    // Ready outputs are gated by rst_n so they are low while reset is held
    // and rise as soon as it is released. A new word may be taken whenever
    // the output register is empty or being emptied this cycle.
    assign req_ready  = rst_n && (state_q == S_IDLE) && !enable_q;
    assign data_ready = rst_n && (state_q != S_IDLE) && (!enable_q || port_up.ack)
                        && (cnt_q != '0);

    // Next-state and output-register logic for the packet FSM.
    always_comb begin
        state_d  = state_q;
        flit_d   = flit_q;
        enable_d = enable_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_hs) begin
                    flit_d   = '{flit_type: HEADER, payload: hdr_to_payload(hdr)};
                    enable_d = 1'b1;
                    cnt_d    = len_clamped;
                    state_d  = S_HEAD;
                end
            end
            S_HEAD: begin
                if (xfer) begin
                    state_d = S_BODY;
                    if (cnt_q == '0) begin
                        // Empty packet: the header is followed by a bare TAIL.
                        flit_d   = '{flit_type: TAIL, payload: '0};
                        enable_d = 1'b1;
                    end else if (data_hs) begin
                        flit_d   = word_flit;
                        enable_d = 1'b1;
                        cnt_d    = cnt_q - LEN_W'(1);
                    end else begin
                        flit_d   = IDLE_FLIT;
                        enable_d = 1'b0;
                    end
                end
            end
            S_BODY: begin
                if (xfer && (flit_q.flit_type == TAIL)) begin
                    flit_d   = IDLE_FLIT;
                    enable_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (data_hs) begin
                    flit_d   = word_flit;
                    enable_d = 1'b1;
                    cnt_d    = cnt_q - LEN_W'(1);
                end else if (xfer) begin
                    // Word not available yet: bubble, never marked TAIL.
                    flit_d   = IDLE_FLIT;
                    enable_d = 1'b0;
                end
            end
            default: begin
                flit_d   = IDLE_FLIT;
                enable_d = 1'b0;
                cnt_d    = '0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State and flit registers; reset abandons any partial packet at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            flit_q   <= IDLE_FLIT;
            enable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            flit_q   <= flit_d;
            enable_q <= enable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign port_up.flit   = flit_q;
    assign port_up.enable = enable_q;
    assign dbg_state_o    = state_q;

`ifdef PACKET_INJECTOR_STATS_EN
    logic pkt_inc;
    logic stall_inc;

    assign pkt_inc   = xfer && (flit_q.flit_type == TAIL);
    assign stall_inc = enable_q && !port_up.ack;

    sat_counter #(.WIDTH(16)) u_pkt_cnt (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .inc_i   (pkt_inc),
        .count_o (pkt_count)
    );

    sat_counter #(.WIDTH(16)) u_stall_cnt (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .inc_i   (stall_inc),
        .count_o (stall_count)
    );
`endif

endmodule

// File: tb/tb_packet_injector.sv
// Bench for packet_injector: a table of per-cycle input/expected-output
// records, plus hand-written sequences for mid-packet reset, length
// clamping and counter saturation. Define PACKET_INJECTOR_STATS_EN to
// also check the statistics outputs.
module tb_packet_injector;
    import noc_pkg::*;

    localparam logic [1:0] TH = 2'd0;
    localparam logic [1:0] TB = 2'd1;
    localparam logic [1:0] TT = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    addr_t       req_dst;
    logic [3:0]  req_len;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] data;
    logic [1:0]  dbg_state;
`ifdef PACKET_INJECTOR_STATS_EN
    logic [15:0] pkt_count;
    logic [15:0] stall_count;
`endif
    logic        sat_inc;
    logic [3:0]  sat_cnt;

    node_port nport ();

    always #5 clk = ~clk;

    packet_injector #(.X(1), .Y(1), .MAX_LEN(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dst     (req_dst),
        .req_len     (req_len),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .data        (data),
        .dbg_state_o (dbg_state),
`ifdef PACKET_INJECTOR_STATS_EN
        .pkt_count   (pkt_count),
        .stall_count (stall_count),
`endif
        .port_up     (nport)
    );

    sat_counter #(.WIDTH(4)) u_sat (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .inc_i   (sat_inc),
        .count_o (sat_cnt)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          grp;
        logic        rv;
        logic [3:0]  dx;
        logic [3:0]  dy;
        logic [3:0]  len;
        logic        dv;
        logic [31:0] d;
        logic        ack;
        logic        e_rr;
        logic        e_dr;
        logic        e_en;
        logic [1:0]  e_ty;
        logic [31:0] e_pl;
    } vec_t;

    vec_t vecs[$];
    int   post_rst_idx;

    function automatic vec_t mk(input int grp, input logic rv, input logic [3:0] dx,
                                input logic [3:0] dy, input logic [3:0] len, input logic dv,
                                input logic [31:0] d, input logic ack, input logic e_rr,
                                input logic e_dr, input logic e_en, input logic [1:0] e_ty,
                                input logic [31:0] e_pl);
        vec_t v;
        v.grp = grp;  v.rv = rv;  v.dx = dx;  v.dy = dy;  v.len = len;
        v.dv = dv;  v.d = d;  v.ack = ack;  v.e_rr = e_rr;  v.e_dr = e_dr;
        v.e_en = e_en;  v.e_ty = e_ty;  v.e_pl = e_pl;
        return v;
    endfunction

    task automatic check(input string name, input int grp, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s grp=%0d t=%0t got=%h want=%h", name, grp, $time, act, exp);
        end
    endtask

    task automatic check_port(input int grp, input logic e_rr, input logic e_dr,
                              input logic e_en, input logic [1:0] e_ty, input logic [31:0] e_pl);
        check("req_ready", grp, 32'(req_ready), 32'(e_rr));
        check("data_ready", grp, 32'(data_ready), 32'(e_dr));
        check("enable", grp, 32'(nport.enable), 32'(e_en));
        check("flit_type", grp, 32'(nport.flit.flit_type), 32'(e_ty));
        check("payload", grp, nport.flit.payload, e_pl);
    endtask

    // Drive one vector after the falling edge, then check the outputs that
    // are valid for the coming rising edge.
    task automatic apply_vec(input vec_t v);
        @(negedge clk);
        req_valid  = v.rv;
        req_dst    = '{x: v.dx, y: v.dy};
        req_len    = v.len;
        data_valid = v.dv;
        data       = v.d;
        nport.ack  = v.ack;
        #1;
        check_port(v.grp, v.e_rr, v.e_dr, v.e_en, v.e_ty, v.e_pl);
    endtask

    task automatic drive_idle();
        req_valid  = 1'b0;
        req_dst    = '0;
        req_len    = '0;
        data_valid = 1'b0;
        data       = '0;
        nport.ack  = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          k;
        int          seen;
        logic        tail_seen;
        logic [31:0] tail_pl;
        logic        fire;

        // Group 1: len=3 to (2,3), ack tied high, back-to-back.
        vecs.push_back(mk(1, 1, 2, 3, 3, 0, 32'h0, 1, 1, 0, 0, TB, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'hA, 1, 0, 1, 1, TH, 32'h2311));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'hB, 1, 0, 1, 1, TB, 32'hA));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'hC, 1, 0, 1, 1, TB, 32'hB));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, TT, 32'hC));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0, 0, TB, 32'h0));
        // Group 2: 2-cycle data gap after word 1 of len=3 -> two bubbles.
        vecs.push_back(mk(2, 1, 5, 6, 3, 0, 32'h0, 1, 1, 0, 0, TB, 32'h0));
        vecs.push_back(mk(2, 0, 0, 0, 0, 1, 32'h11110001, 1, 0, 1, 1, TH, 32'h5611));
        vecs.push_back(mk(2, 0, 0, 0, 0, 0, 32'h0, 1, 0, 1, 1, TB, 32'h11110001));
        vecs.push_back(mk(2, 0, 0, 0, 0, 0, 32'h0, 1, 0, 1, 0, TB, 32'h0));
        vecs.push_back(mk(2, 0, 0, 0, 0, 1, 32'h11110002, 1, 0, 1, 0, TB, 32'h0));
        vecs.push_back(mk(2, 0, 0, 0, 0, 1, 32'h11110003, 1, 0, 1, 1, TB, 32'h11110002));
        vecs.push_back(mk(2, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, TT, 32'h11110003));
        vecs.push_back(mk(2, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0, 0, TB, 32'h0));
        // Group 3: ack held low for 5 cycles during the HEADER.
        vecs.push_back(mk(3, 1, 7, 0, 1, 0, 32'h0, 0, 1, 0, 0, TB, 32'h0));
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(3, 0, 0, 0, 0, 1, 32'hE0, 0, 0, 0, 1, TH, 32'h7011));
        end
        vecs.push_back(mk(3, 0, 0, 0, 0, 1, 32'hE0, 1, 0, 1, 1, TH, 32'h7011));
        vecs.push_back(mk(3, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, TT, 32'hE0));
        vecs.push_back(mk(3, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0, 0, TB, 32'h0));
        // Group 4: len=0 twice; the second request waits one cycle after the TAIL.
        vecs.push_back(mk(4, 1, 3, 3, 0, 1, 32'hDEAD, 1, 1, 0, 0, TB, 32'h0));
        vecs.push_back(mk(4, 0, 0, 0, 0, 1, 32'hDEAD, 1, 0, 0, 1, TH, 32'h3311));
        vecs.push_back(mk(4, 1, 3, 3, 0, 1, 32'hDEAD, 1, 0, 0, 1, TT, 32'h0));
        vecs.push_back(mk(4, 1, 3, 3, 0, 1, 32'hDEAD, 1, 1, 0, 0, TB, 32'h0));
        vecs.push_back(mk(4, 0, 0, 0, 0, 1, 32'hDEAD, 1, 0, 0, 1, TH, 32'h3311));
        vecs.push_back(mk(4, 0, 0, 0, 0, 1, 32'hDEAD, 1, 0, 0, 1, TT, 32'h0));
        vecs.push_back(mk(4, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0, 0, TB, 32'h0));
        post_rst_idx = vecs.size();
        // Group 5: len=1 to (1,2) right after a mid-packet reset.
        vecs.push_back(mk(5, 1, 1, 2, 1, 0, 32'h0, 1, 1, 0, 0, TB, 32'h0));
        vecs.push_back(mk(5, 0, 0, 0, 0, 1, 32'hF00D, 1, 0, 1, 1, TH, 32'h1211));
        vecs.push_back(mk(5, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, TT, 32'hF00D));
        vecs.push_back(mk(5, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0, 0, TB, 32'h0));

        // Reset state, with a request already pending.
        rst_n   = 1'b0;
        sat_inc = 1'b0;
        drive_idle();
        req_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_port(0, 1'b0, 1'b0, 1'b0, TB, 32'h0);
        check("dbg_state", 0, 32'(dbg_state), 32'd0);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        #1;
        check("req_ready_release", 0, 32'(req_ready), 32'd1);

        for (int i = 0; i < post_rst_idx; i++) apply_vec(vecs[i]);

`ifdef PACKET_INJECTOR_STATS_EN
        check("pkt_count", 4, 32'(pkt_count), 32'd5);
        check("stall_count", 4, 32'(stall_count), 32'd5);
`endif

        // Mid-packet reset once the second BODY flit is on the link.
        @(negedge clk);
        req_valid = 1'b1;  req_dst = '{x: 4'd2, y: 4'd3};  req_len = 4'd3;
        data_valid = 1'b0;  nport.ack = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;  data_valid = 1'b1;  data = 32'hA;
        @(negedge clk);
        data = 32'hB;
        @(negedge clk);
        data_valid = 1'b0;
        #1;
        check("pre_rst_enable", 6, 32'(nport.enable), 32'd1);
        check("pre_rst_payload", 6, nport.flit.payload, 32'hB);
        rst_n = 1'b0;
        #1;
        check_port(6, 1'b0, 1'b0, 1'b0, TB, 32'h0);
        check("dbg_state_rst", 6, 32'(dbg_state), 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        #1;
        check("req_ready_after_rst", 6, 32'(req_ready), 32'd1);
        check("enable_after_rst", 6, 32'(nport.enable), 32'd0);

        for (int i = post_rst_idx; i < vecs.size(); i++) apply_vec(vecs[i]);

        // Over-long request (15) is clamped to 8 payload flits.
        @(negedge clk);
        req_valid = 1'b1;  req_dst = '{x: 4'd4, y: 4'd4};  req_len = 4'd15;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        k = 0;  seen = 0;  tail_seen = 1'b0;  tail_pl = '0;
        for (int c = 0; c < 20 && !tail_seen; c++) begin
            @(negedge clk);
            data_valid = 1'b1;
            data       = 32'(100 + k);
            nport.ack  = 1'b1;
            #1;
            if (nport.enable) begin
                if (nport.flit.flit_type == TAIL) begin
                    tail_seen = 1'b1;
                    tail_pl   = nport.flit.payload;
                    seen++;
                end else if (nport.flit.flit_type == BODY) begin
                    seen++;
                end
            end
            fire = data_ready;
            @(posedge clk);
            if (fire) k++;
        end
        check("clamp_tail_seen", 7, 32'(tail_seen), 32'd1);
        check("clamp_flits", 7, 32'(seen), 32'd8);
        check("clamp_words", 7, 32'(k), 32'd8);
        check("clamp_tail_payload", 7, tail_pl, 32'd107);
        @(negedge clk);
        drive_idle();
        #1;
        check("clamp_idle_ready", 7, 32'(req_ready), 32'd1);

`ifdef PACKET_INJECTOR_STATS_EN
        check("pkt_count_post", 7, 32'(pkt_count), 32'd2);
        check("stall_count_post", 7, 32'(stall_count), 32'd0);
`endif

        // Saturating counter on its own at 4 bits.
        @(negedge clk);
        check("sat_start", 8, 32'(sat_cnt), 32'd0);
        sat_inc = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        sat_inc = 1'b0;
        check("sat_mid", 8, 32'(sat_cnt), 32'd10);
        sat_inc = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        sat_inc = 1'b0;
        check("sat_full", 8, 32'(sat_cnt), 32'd15);
        repeat (3) @(posedge clk);
        #1;
        check("sat_hold", 8, 32'(sat_cnt), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
